multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the core datapath: ALU, register file, instruction and data memory.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath strobes (reg_write, mem_read, mem_write, alu_op) one phase at a time.
- Runs request/acknowledge handshakes with instruction and data memory, with a wait timeout.
- Sits between the instruction register / PC logic and the datapath; sole owner of all datapath write enables.

---
 rtl/multicycle_ctrl_pkg.sv | 31 +++
 rtl/multicycle_ctrl_if.sv | 30 +++
 rtl/multicycle_ctrl_ack_wait_timer.sv | 28 ++
 rtl/multicycle_ctrl.sv | 92 +++++++++
 tb/tb_multicycle_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants and state type for the multi-cycle datapath sequencer.
// Holds the opcode map, ALU encodings and the controller state enum.
package ctrl_pkg;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } ctrl_state_t;

    function automatic logic op_is_mem(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || op_is_mem(op);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake bundle between the sequencer and memories.
// The controller is the master: it raises requests and receives acks.
interface multicycle_ctrl_if;

    logic imem_req;
    logic imem_ack;
    logic ir_load;
    logic mem_read;
    logic mem_write;
    logic dmem_ack;

    modport master (
        output imem_req,
        output ir_load,
        output mem_read,
        output mem_write,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  ir_load,
        input  mem_read,
        input  mem_write,
        output imem_ack,
        output dmem_ack
    );

endinterface

// File: rtl/multicycle_ctrl_ack_wait_timer.sv
// Counts cycles a memory request has waited without ack; shared by FETCH and MEM.
// expired fires combinationally in the wait cycle where the count reaches the limit.
module ack_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick && !expired) begin
            count <= count + W'(1);
        end
    end

    // An ack in the limit cycle drops tick, so a late ack still wins.
    assign expired = tick && (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: steps each instruction through fetch, decode, execute,
// memory and writeback, and owns every datapath write enable.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [5:0]           opcode,
    multicycle_ctrl_if.master    bus,
    output logic                 pc_inc,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic                 instr_done,
    output logic                 illegal_op,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     retired
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic [5:0]  op_q;
    logic        wait_clear;
    logic        wait_tick;
    logic        wait_expired;

    assign wait_clear = !((state == ST_FETCH) || (state == ST_MEM));
    assign wait_tick  = ((state == ST_FETCH) && !bus.imem_ack) ||
                        ((state == ST_MEM)   && !bus.dmem_ack);

    ack_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (wait_clear),
        .tick    (wait_tick),
        .expired (wait_expired)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (en) state_next = ST_FETCH;
            ST_FETCH: begin
                if (bus.imem_ack)       state_next = ST_DECODE;
                else if (wait_expired)  state_next = ST_HALT;
            end
            ST_DECODE: state_next = op_is_legal(opcode) ? ST_EXEC : ST_HALT;
            ST_EXEC:   state_next = op_is_mem(op_q) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (bus.dmem_ack)       state_next = ST_WB;
                else if (wait_expired)  state_next = ST_HALT;
            end
            ST_WB:     state_next = en ? ST_FETCH : ST_IDLE;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            retired     <= '0;
            illegal_op  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) begin
                op_q <= opcode;
                if (!op_is_legal(opcode)) illegal_op <= 1'b1;
            end
            if (wait_expired) timeout_err <= 1'b1;
            if (state == ST_WB) retired <= retired + CNT_W'(1);
        end
    end

    // Strobes decode from state and the latched opcode; only one phase is live at a time.
    assign bus.imem_req  = (state == ST_FETCH);
    assign bus.ir_load   = (state == ST_FETCH) && bus.imem_ack;
    assign bus.mem_read  = (state == ST_MEM) && (op_q == OP_LW);
    assign bus.mem_write = (state == ST_MEM) && (op_q == OP_SW);
    assign alu_op        = ((state == ST_EXEC) && (op_q == OP_SUB)) ? ALU_SUB : ALU_ADD;
    assign pc_inc        = (state == ST_WB);
    assign instr_done    = (state == ST_WB);
    assign reg_write     = (state == ST_WB) && (op_q != OP_SW);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected traces built from
// the phase/latency rules, with randomized don't-care inputs around them.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en;
    logic [5:0]  opcode;
    logic        pc_inc, reg_write, instr_done, illegal_op, timeout_err;
    logic [1:0]  alu_op;
    logic [15:0] retired;
    multicycle_ctrl_if bus();

    multicycle_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .bus(bus),
        .pc_inc(pc_inc), .alu_op(alu_op), .reg_write(reg_write),
        .instr_done(instr_done), .illegal_op(illegal_op),
        .timeout_err(timeout_err), .retired(retired)
    );

    // Narrow-counter instance for the retire wrap boundary.
    logic        en2;
    logic [5:0]  op2;
    logic        pc_inc2, reg_write2, instr_done2, illegal_op2, timeout_err2;
    logic [1:0]  alu_op2;
    logic [2:0]  retired2;
    multicycle_ctrl_if bus2();

    multicycle_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .opcode(op2), .bus(bus2),
        .pc_inc(pc_inc2), .alu_op(alu_op2), .reg_write(reg_write2),
        .instr_done(instr_done2), .illegal_op(illegal_op2),
        .timeout_err(timeout_err2), .retired(retired2)
    );

    typedef struct {
        logic        r, e, ia, da;
        logic [5:0]  op;
        logic [10:0] exp;
        logic [15:0] ret;
    } cyc_t;

    cyc_t        tr[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [15:0] exp_ret = '0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    function automatic logic legal(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_LW, OP_SW};
    endfunction

    // {imem_req, ir_load, pc_inc, alu_op, mem_read, mem_write, reg_write, instr_done, illegal_op, timeout_err}
    function automatic logic [10:0] ov(input logic ireq, ild, pci, input logic [1:0] alu,
                                       input logic mr, mw, rw, dn, ill, to);
        return {ireq, ild, pci, alu, mr, mw, rw, dn, ill, to};
    endfunction

    function automatic cyc_t mk(input logic r, e, ia, da, input logic [5:0] op,
                                input logic [10:0] x, input logic [15:0] ret);
        cyc_t c;
        c.r = r; c.e = e; c.ia = ia; c.da = da; c.op = op; c.exp = x; c.ret = ret;
        return c;
    endfunction

    task automatic add_idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++)
            tr.push_back(mk(0, 0, rb(), rb(), rnd_op(), '0, exp_ret));
    endtask

    task automatic add_start();
        tr.push_back(mk(0, 1, rb(), rb(), rnd_op(), '0, exp_ret));
    endtask

    task automatic add_halt(input int unsigned n, input logic ill, input logic to);
        for (int unsigned k = 0; k < n; k++)
            tr.push_back(mk(0, rb(), rb(), rb(), rnd_op(),
                            ov(0, 0, 0, 2'b00, 0, 0, 0, 0, ill, to), exp_ret));
    endtask

    // One instruction: fetch waits iw cycles, memory waits dw cycles; 16+ waits time out.
    task automatic add_instr(input logic [5:0] op, input int unsigned iw,
                             input int unsigned dw, input logic en_next);
        for (int unsigned k = 0; k <= iw && k < 16; k++)
            tr.push_back(mk(0, rb(), (k == iw), rb(), rnd_op(),
                            ov(1, (k == iw), 0, 2'b00, 0, 0, 0, 0, 0, 0), exp_ret));
        if (iw >= 16) return;
        tr.push_back(mk(0, rb(), rb(), rb(), op, '0, exp_ret));
        if (!legal(op)) return;
        tr.push_back(mk(0, rb(), rb(), rb(), rnd_op(),
                        ov(0, 0, 0, (op == OP_SUB) ? 2'b01 : 2'b00, 0, 0, 0, 0, 0, 0), exp_ret));
        if (op == OP_LW || op == OP_SW) begin
            for (int unsigned k = 0; k <= dw && k < 16; k++)
                tr.push_back(mk(0, rb(), rb(), (k == dw), rnd_op(),
                                ov(0, 0, 0, 2'b00, op == OP_LW, op == OP_SW, 0, 0, 0, 0), exp_ret));
            if (dw >= 16) return;
        end
        tr.push_back(mk(0, en_next, rb(), rb(), rnd_op(),
                        ov(0, 0, 1, 2'b00, 0, 0, op != OP_SW, 1, 0, 0), exp_ret));
        exp_ret = exp_ret + 16'd1;
    endtask

    // Called at posedge+1: drive, sample at posedge+2, advance to next posedge+1.
    task automatic step(input cyc_t c, output logic [10:0] o, output logic [15:0] rt);
        rst = c.r; en = c.e; bus.imem_ack = c.ia; bus.dmem_ack = c.da; opcode = c.op;
        #1;
        o  = {bus.imem_req, bus.ir_load, pc_inc, alu_op, bus.mem_read, bus.mem_write,
              reg_write, instr_done, illegal_op, timeout_err};
        rt = retired;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] o; logic [15:0] rt;
        tr.delete();
        step(mk(1, rb(), rb(), rb(), rnd_op(), '0, '0), o, rt);
        step(mk(1, rb(), rb(), rb(), rnd_op(), '0, '0), o, rt);
        exp_ret = '0;
        add_idle(4);
        foreach (tr[i]) begin
            step(tr[i], o, rt);
            total++;
            if (o !== tr[i].exp || rt !== tr[i].ret) begin
                bad++;
                $display("FAIL reset cyc%0d: got %b ret=%0d, want %b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
            end
        end
    endtask

    task automatic test_add();
        logic [10:0] o; logic [15:0] rt;
        tr.delete();
        add_start();
        add_instr(OP_ADD, 0, 0, 0);
        add_idle(2);
        foreach (tr[i]) begin
            step(tr[i], o, rt);
            total++;
            if (o !== tr[i].exp || rt !== tr[i].ret) begin
                bad++;
                $display("FAIL add cyc%0d: got %b ret=%0d, want %b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
            end
        end
    endtask

    task automatic test_sub_lw_sw();
        logic [10:0] o; logic [15:0] rt;
        tr.delete();
        add_start();
        add_instr(OP_SUB, 0, 0, 1);
        add_instr(OP_LW, 1, 3, 0);
        add_idle(1);
        add_start();
        add_instr(OP_SW, 0, 0, 0);
        add_idle(1);
        foreach (tr[i]) begin
            step(tr[i], o, rt);
            total++;
            if (o !== tr[i].exp || rt !== tr[i].ret) begin
                bad++;
                $display("FAIL sub_lw_sw cyc%0d: got %b ret=%0d, want %b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
            end
        end
    endtask

    task automatic test_en_drop();
        logic [10:0] o; logic [15:0] rt; cyc_t c; int unsigned idx;
        tr.delete();
        add_start();
        idx = tr.size();
        add_instr(OP_SUB, 1, 0, 0);
        for (int unsigned i = idx; i < tr.size(); i++) begin
            c = tr[i];
            c.e = (i < idx + 3);
            tr[i] = c;
        end
        add_idle(4);
        foreach (tr[i]) begin
            step(tr[i], o, rt);
            total++;
            if (o !== tr[i].exp || rt !== tr[i].ret) begin
                bad++;
                $display("FAIL en_drop cyc%0d: got %b ret=%0d, want %b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] o; logic [15:0] rt; logic parked; logic en_next;
        logic [5:0] ops[4];
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_LW; ops[3] = OP_SW;
        tr.delete();
        parked = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (parked) begin
                add_idle($urandom_range(0, 2));
                add_start();
            end
            en_next = (n != 39) && ($urandom_range(0, 3) != 0);
            add_instr(ops[$urandom_range(0, 3)], $urandom_range(0, 3), $urandom_range(0, 3), en_next);
            parked = !en_next;
        end
        add_idle(1);
        foreach (tr[i]) begin
            step(tr[i], o, rt);
            total++;
            if (o !== tr[i].exp || rt !== tr[i].ret) begin
                bad++;
                $display("FAIL random cyc%0d: got %b ret=%0d, want %b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
            end
        end
    endtask

    task automatic test_illegal();
        logic [10:0] o; logic [15:0] rt; logic [5:0] bad_op;
        tr.delete();
        add_start();
        add_instr(6'b111111, 0, 0, 0);
        add_halt(5, 1, 0);
        tr.push_back(mk(1, rb(), rb(), rb(), rnd_op(), ov(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0), exp_ret));
        exp_ret = '0;
        add_idle(2);
        do bad_op = rnd_op(); while (legal(bad_op));
        add_start();
        add_instr(bad_op, 1, 0, 0);
        add_halt(3, 1, 0);
        tr.push_back(mk(1, rb(), rb(), rb(), rnd_op(), ov(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0), exp_ret));
        exp_ret = '0;
        add_idle(1);
        add_start();
        add_instr(OP_ADD, 0, 0, 0);
        add_idle(1);
        foreach (tr[i]) begin
            step(tr[i], o, rt);
            total++;
            if (o !== tr[i].exp || rt !== tr[i].ret) begin
                bad++;
                $display("FAIL illegal cyc%0d: got %b ret=%0d, want %b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
            end
        end
    endtask

    task automatic test_timeout();
        logic [10:0] o; logic [15:0] rt;
        tr.delete();
        add_start();
        add_instr(OP_ADD, 16, 0, 0);
        add_halt(4, 0, 1);
        tr.push_back(mk(1, rb(), rb(), rb(), rnd_op(), ov(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1), exp_ret));
        exp_ret = '0;
        add_idle(1);
        add_start();
        add_instr(OP_ADD, 15, 0, 1);
        add_instr(OP_SW, 0, 15, 1);
        add_instr(OP_LW, 0, 16, 0);
        add_halt(3, 0, 1);
        tr.push_back(mk(1, rb(), rb(), rb(), rnd_op(), ov(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1), exp_ret));
        exp_ret = '0;
        add_idle(1);
        foreach (tr[i]) begin
            step(tr[i], o, rt);
            total++;
            if (o !== tr[i].exp || rt !== tr[i].ret) begin
                bad++;
                $display("FAIL timeout cyc%0d: got %b ret=%0d, want %b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] o; logic [15:0] rt; cyc_t c;
        tr.delete();
        add_start();
        add_instr(OP_ADD, 0, 0, 0);
        add_start();
        add_instr(OP_LW, 0, 5, 0);
        while (tr.size() > 12) void'(tr.pop_back());
        c = tr[11];
        c.r = 1'b1;
        tr[11] = c;
        exp_ret = '0;
        add_idle(2);
        add_start();
        add_instr(OP_ADD, 0, 0, 0);
        add_idle(1);
        foreach (tr[i]) begin
            step(tr[i], o, rt);
            total++;
            if (o !== tr[i].exp || rt !== tr[i].ret) begin
                bad++;
                $display("FAIL reset_mid cyc%0d: got %b ret=%0d, want %b ret=%0d", i, o, rt, tr[i].exp, tr[i].ret);
            end
        end
    endtask

    task automatic test_wrap();
        int unsigned n = 0;
        logic [2:0] want;
        rst = 1'b0; en = 1'b0;
        en2 = 1'b1;
        for (int c = 0; c < 80 && n < 9; c++) begin
            #1;
            if (instr_done2 === 1'b1) begin
                n++;
                if (n == 9) en2 = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        #1;
        want = 3'(9 % 8);
        total++;
        if (n != 9) begin
            bad++;
            $display("FAIL wrap_retires: got %0d, want 9", n);
        end
        total++;
        if (retired2 !== want) begin
            bad++;
            $display("FAIL wrap_count: got %0d, want %0d", retired2, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; opcode = '0;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        en2 = 1'b0; op2 = OP_ADD;
        bus2.imem_ack = 1'b1; bus2.dmem_ack = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_sub_lw_sw();
        test_en_drop();
        test_random();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
